axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
// PURPOSE
//  AXI4 memory responder with single-ported, on-chip word storage, ID echo and byte strobes.
//  Target end of the controller's AXI4 port, used as a drop-in stand-in for axi_ddr3_lite on
//  boards without DDR3, and as a golden responder for benching AXI initiators.
//  Serves one burst at a time; write and read requests are arbitrated fairly.
// PARAMETERS
//  DATA_WIDTH    32  AXI data width (bits), multiple of 8
//  ADDR_WIDTH    10  word address width; storage depth = 2**ADDR_WIDTH words
//  AXI_ID_WIDTH  4   transaction ID width
// PORTS
//  clock          in   1     system clock
//  reset_ni       in   1     asynchronous, active-low reset
//  axi_awvalid_i  in   1     write-address valid
//  axi_awready_o  out  1     write-address ready
//  axi_awaddr_i   in   AW    word address (AW = ADDR_WIDTH)
//  axi_awid_i     in   ID    write ID (ID = AXI_ID_WIDTH)
//  axi_awlen_i    in   8     beats - 1
//  axi_awburst_i  in   2     00 FIXED, 01 INCR, 10 WRAP
//  axi_wvalid_i   in   1     write-data valid
//  axi_wready_o   out  1     write-data ready
//  axi_wlast_i    in   1     last write beat
//  axi_wstrb_i    in   DW/8  byte strobes
//  axi_wdata_i    in   DW    write data
//  axi_bvalid_o   out  1     write response valid
//  axi_bready_i   in   1     write response ready
//  axi_bresp_o    out  2     00 OKAY, 10 SLVERR
//  axi_bid_o      out  ID    echoed awid
//  axi_arvalid_i  in   1     read-address valid
//  axi_arready_o  out  1     read-address ready
//  axi_araddr_i   in   AW    word address
//  axi_arid_i     in   ID    read ID
//  axi_arlen_i    in   8     beats - 1
//  axi_arburst_i  in   2     burst type
//  axi_rvalid_o   out  1     read-data valid
//  axi_rready_i   in   1     read-data ready
//  axi_rlast_o    out  1     last read beat
//  axi_rresp_o    out  2     00 OKAY, 10 SLVERR
//  axi_rid_o      out  ID    echoed arid
//  axi_rdata_o    out  DW    read data
// BEHAVIOUR
//  - Reset (reset_ni low, async): all outputs 0, FSM in IDLE, priority flag = write-first. Readies
//    stay 0 until the first rising edge after reset_ni rises (registered enable). Storage is not cleared.
//  - FSM: IDLE -> WDATA -> BRESP -> IDLE; IDLE -> RDATA -> IDLE.
//  - IDLE: awready = en & (~arvalid | ~prio_rd); arready = en & (~awvalid | prio_rd).
//    prio_rd toggles on every accepted address, so simultaneous requests alternate write/read.
//  - WDATA: wready = 1. On each beat, bytes with wstrb=1 are written. Address update:
//    FIXED holds, INCR +1 (mod 2**AW), WRAP per AXI (len 1/3/7/15 only).
//  - Burst ends on the beat with wlast. If wlast comes before awlen+1 beats: bresp=SLVERR.
//    Beats beyond awlen+1 are accepted and discarded until wlast, then bresp=SLVERR.
//  - BRESP: bvalid=1 with bid=awid, held until bready. Then IDLE.
//    Earliest next address accept is the cycle after the B handshake.
//  - RDATA: first rvalid one cycle after the AR handshake.
//  - Read throughput: 1 beat/cycle while rready=1.
//  - While rvalid & ~rready: rdata, rlast, rid and rresp are held stable.
//  - rlast on beat arlen. IDLE follows the last R handshake.
//  - Illegal WRAP len (not 1/3/7/15), or reserved burst type 11: the burst is fully
//    handshaked and reported SLVERR; writes are discarded and rdata = 0.
//  - Read/write to the same address are never concurrent (single outstanding burst).
// CONFIGURATION
//  AXI_WRAP_BURST_EN defined: WRAP bursts are supported as above.
//  Not defined: burst type 10 is treated like type 11 (SLVERR, no write, rdata = 0).
//  No WRAP address logic is synthesised.
// TESTING
//  1. INCR write at addr 0, len 3, data 11111111..44444444, wstrb f -> bresp 00, bid = awid.
//     Read back at addr 0, len 3 -> the same 4 words, rlast on beat 3, rid = arid.
//  2. Partial strobes: write A5A5A5A5 with wstrb 0101 over prior FFFFFFFF -> read gives FFA5FFA5.
//  3. AW and AR valid in the same cycle, twice -> grants write, read, write, read in order.
//     No lost or duplicated handshake.
//  4. Read len 7 with rready toggling 1,0,0,1... -> 8 beats in order, data stable while stalled.
//     rlast only on beat 7.
//  5. Write len 3 with wlast on beat 1 -> bresp 10.
//     Write len 1 with wlast on beat 3 -> bresp 10, beats 2-3 not stored.
//  6. WRAP len 3 at addr 6 -> addresses 6,7,4,5 with _EN. Without _EN -> rresp 10, rdata 0.
//     Assert reset_ni low mid-burst -> all outputs 0 immediately; next burst completes OKAY.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI4 responder over on-chip word storage: one burst at a time, fair AW/AR arbitration.
// Define AXI_WRAP_BURST_EN to support WRAP bursts; otherwise type 10 answers SLVERR.
module axi_sram_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int AXI_ID_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_ni,
  input  logic                      axi_awvalid_i,
  output logic                      axi_awready_o,
  input  logic [ADDR_WIDTH-1:0]     axi_awaddr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_awid_i,
  input  logic [7:0]                axi_awlen_i,
  input  logic [1:0]                axi_awburst_i,
  input  logic                      axi_wvalid_i,
  output logic                      axi_wready_o,
  input  logic                      axi_wlast_i,
  input  logic [DATA_WIDTH/8-1:0]   axi_wstrb_i,
  input  logic [DATA_WIDTH-1:0]     axi_wdata_i,
  output logic                      axi_bvalid_o,
  input  logic                      axi_bready_i,
  output logic [1:0]                axi_bresp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_bid_o,
  input  logic                      axi_arvalid_i,
  output logic                      axi_arready_o,
  input  logic [ADDR_WIDTH-1:0]     axi_araddr_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_arid_i,
  input  logic [7:0]                axi_arlen_i,
  input  logic [1:0]                axi_arburst_i,
  output logic                      axi_rvalid_o,
  input  logic                      axi_rready_i,
  output logic                      axi_rlast_o,
  output logic [1:0]                axi_rresp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_rid_o,
  output logic [DATA_WIDTH-1:0]     axi_rdata_o
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE, WDATA, BRESP, RDATA
  } state_t;

  state_t state_q, state_d;

  logic                    en_q, prio_rd_q;
  logic                    over_q, bad_q, err_q, rlast_q;
  logic [7:0]              len_q, cnt_q;
  logic [1:0]              burst_q, rresp_q;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [ADDR_WIDTH-1:0]   addr_q, nxt;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    aw_hs, ar_hs, w_hs, r_hs;
  logic                    aw_bad, ar_bad, we;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

`ifdef AXI_WRAP_BURST_EN
  function automatic logic is_bad(input logic [1:0] b,
                                  input logic [7:0] l);
    return (b == 2'b11) ||
           (b == 2'b10 && !(l == 8'd1 || l == 8'd3 ||
                            l == 8'd7 || l == 8'd15));
  endfunction

  logic [ADDR_WIDTH-1:0] wmask;
  assign wmask  = ADDR_WIDTH'(len_q);
  assign aw_bad = is_bad(axi_awburst_i, axi_awlen_i);
  assign ar_bad = is_bad(axi_arburst_i, axi_arlen_i);
`else
  assign aw_bad = axi_awburst_i[1];
  assign ar_bad = axi_arburst_i[1];
`endif

  // Address of the beat following addr_q in the current burst.
  always_comb begin
    nxt = addr_q;
    case (burst_q)
      2'b01: nxt = addr_q + ADDR_WIDTH'(1);
`ifdef AXI_WRAP_BURST_EN
      2'b10: nxt = (addr_q & ~wmask) |
                   ((addr_q + ADDR_WIDTH'(1)) & wmask);
`endif
      default: nxt = addr_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    axi_rvalid_o  = 1'b0;
    aw_hs         = 1'b0;
    ar_hs         = 1'b0;
    w_hs          = 1'b0;
    r_hs          = 1'b0;
    unique case (state_q)
      IDLE: begin
        axi_awready_o = en_q & (~axi_arvalid_i | ~prio_rd_q);
        axi_arready_o = en_q & (~axi_awvalid_i | prio_rd_q);
        aw_hs = axi_awvalid_i & axi_awready_o;
        ar_hs = axi_arvalid_i & axi_arready_o;
        if (aw_hs) state_d = WDATA;
        else if (ar_hs) state_d = RDATA;
      end
      WDATA: begin
        axi_wready_o = 1'b1;
        w_hs = axi_wvalid_i;
        if (w_hs && axi_wlast_i) state_d = BRESP;
      end
      BRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_d = IDLE;
      end
      RDATA: begin
        axi_rvalid_o = 1'b1;
        r_hs = axi_rready_i;
        if (r_hs && rlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign we = w_hs & ~over_q & ~bad_q;

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      prio_rd_q <= 1'b0;
      over_q    <= 1'b0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
      rlast_q   <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      burst_q   <= '0;
      rresp_q   <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      if (aw_hs || ar_hs) prio_rd_q <= ~prio_rd_q;
      if (aw_hs) begin
        addr_q  <= axi_awaddr_i;
        id_q    <= axi_awid_i;
        len_q   <= axi_awlen_i;
        burst_q <= axi_awburst_i;
        cnt_q   <= '0;
        over_q  <= 1'b0;
        err_q   <= 1'b0;
        bad_q   <= aw_bad;
      end
      if (w_hs) begin
        // Beats past awlen are swallowed once over_q is set.
        if (!over_q) begin
          addr_q <= nxt;
          if (cnt_q == len_q) over_q <= ~axi_wlast_i;
          else cnt_q <= cnt_q + 8'd1;
        end
        if (axi_wlast_i)
          err_q <= bad_q | over_q | (cnt_q != len_q);
      end
      if (ar_hs) begin
        addr_q  <= axi_araddr_i;
        id_q    <= axi_arid_i;
        len_q   <= axi_arlen_i;
        burst_q <= axi_arburst_i;
        cnt_q   <= '0;
        bad_q   <= ar_bad;
        rresp_q <= {ar_bad, 1'b0};
        rlast_q <= (axi_arlen_i == 8'd0);
        rdata_q <= ar_bad ? '0 : mem[axi_araddr_i];
      end
      if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          addr_q  <= nxt;
          cnt_q   <= cnt_q + 8'd1;
          rlast_q <= (cnt_q + 8'd1 == len_q);
          rdata_q <= bad_q ? '0 : mem[nxt];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < SW; i++)
      if (we && axi_wstrb_i[i])
        mem[addr_q][8*i +: 8] <= axi_wdata_i[8*i +: 8];
  end

  assign axi_bresp_o = {err_q, 1'b0};
  assign axi_bid_o   = id_q;
  assign axi_rid_o   = id_q;
  assign axi_rresp_o = rresp_q;
  assign axi_rlast_o = rlast_q;
  assign axi_rdata_o = rdata_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a reference memory and response queues.
// Honours AXI_WRAP_BURST_EN the same way the design does.
module tb_axi_sram_responder;

  logic        clock = 1'b0;
  logic        reset_ni = 1'b0;
  logic        awvalid = 0, awready;
  logic [9:0]  awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready, wlast = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] wdata = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [9:0]  araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0, rlast;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic [31:0] rdata;

  always #5 clock = ~clock;

  axi_sram_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .AXI_ID_WIDTH(4)
  ) dut (
    .clock(clock), .reset_ni(reset_ni),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_awaddr_i(awaddr), .axi_awid_i(awid),
    .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_wlast_i(wlast), .axi_wstrb_i(wstrb),
    .axi_wdata_i(wdata),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_araddr_i(araddr), .axi_arid_i(arid),
    .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .axi_rlast_o(rlast), .axi_rresp_o(rresp),
    .axi_rid_o(rid), .axi_rdata_o(rdata)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  r;
    logic [3:0]  id;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [5:0]  bq[$];
  logic [31:0] model [0:1023];
  int passed = 0, total = 0;
  int aw_cnt = 0, ar_cnt = 0;

  always @(posedge clock) begin
    if (awvalid && awready) aw_cnt++;
    if (arvalid && arready) ar_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic is_bad(input logic [1:0] b, input logic [7:0] l);
`ifdef AXI_WRAP_BURST_EN
    return (b == 2'b11) ||
           (b == 2'b10 && !(l == 1 || l == 3 || l == 7 || l == 15));
`else
    return b[1] | (l == 8'hff && 1'b0);
`endif
  endfunction

  function automatic logic [9:0] beat_addr(input logic [9:0] a,
    input logic [1:0] b, input logic [7:0] l, input int i);
    logic [9:0] m;
    m = 10'(l);
    case (b)
      2'b01:   return a + 10'(i);
      2'b10:   return (a & ~m) | ((a + 10'(i)) & m);
      default: return a;
    endcase
  endfunction

  task automatic send_aw(input logic [9:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    awvalid = 1; awaddr = a; awid = id; awlen = len; awburst = b;
    #1;
    while (!awready && n < 100) begin @(negedge clock); #1; n++; end
    if (n == 100) check("aw_timeout", 0, 1);
    @(negedge clock);
    awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input logic last);
    int n = 0;
    wvalid = 1; wdata = d; wstrb = s; wlast = last;
    #1;
    while (!wready && n < 100) begin @(negedge clock); #1; n++; end
    if (n == 100) check("w_timeout", 0, 1);
    @(negedge clock);
    wvalid = 0; wlast = 0;
  endtask

  task automatic get_b();
    int n = 0;
    logic [5:0] e;
    bready = 1;
    #1;
    while (!bvalid && n < 100) begin @(negedge clock); #1; n++; end
    if (n == 100) check("b_timeout", 0, 1);
    else begin
      e = bq.pop_front();
      check("bresp", bresp, e[5:4]);
      check("bid", bid, e[3:0]);
    end
    @(negedge clock);
    bready = 0;
  endtask

  task automatic send_ar(input logic [9:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    arvalid = 1; araddr = a; arid = id; arlen = len; arburst = b;
    #1;
    while (!arready && n < 100) begin @(negedge clock); #1; n++; end
    if (n == 100) check("ar_timeout", 0, 1);
    @(negedge clock);
    arvalid = 0;
  endtask

  task automatic recv_r(input int mode);
    int k = 0;
    logic stalled = 0;
    logic [31:0] sd;
    logic sl;
    rbeat_t e;
    while (rq.size() > 0 && k < 300) begin
      rready = (mode == 0) ? 1'b1 : (k % 3 == 0);
      #1;
      if (stalled) begin
        check("r_stall_valid", rvalid, 1);
        check("r_stall_data", rdata, sd);
        check("r_stall_last", rlast, sl);
      end
      stalled = 0;
      if (rvalid) begin
        if (rready) begin
          e = rq.pop_front();
          check("rdata", rdata, e.d);
          check("rlast", rlast, e.l);
          check("rresp", rresp, e.r);
          check("rid", rid, e.id);
        end else begin
          stalled = 1; sd = rdata; sl = rlast;
        end
      end
      @(negedge clock);
      k++;
    end
    if (rq.size() > 0) begin
      check("r_timeout", 0, 1);
      rq.delete();
    end
    rready = 0;
    #1;
    check("r_done_idle", rvalid, 0);
    @(negedge clock);
  endtask

  task automatic write_burst(input logic [9:0] a, input logic [3:0] id,
    input logic [7:0] len, input logic [1:0] b, input int nb,
    input logic [31:0] base, input logic [31:0] step, input logic [3:0] s);
    logic bad;
    logic [31:0] d;
    logic [9:0] ad;
    bad = is_bad(b, len);
    bq.push_back({(bad || nb != len + 1) ? 2'b10 : 2'b00, id});
    send_aw(a, id, len, b);
    for (int i = 0; i < nb; i++) begin
      d = base + step * i;
      if (!bad && i <= len) begin
        ad = beat_addr(a, b, len, i);
        for (int j = 0; j < 4; j++)
          if (s[j]) model[ad][8*j +: 8] = d[8*j +: 8];
      end
      send_w(d, s, i == nb - 1);
    end
    get_b();
  endtask

  task automatic read_burst(input logic [9:0] a, input logic [3:0] id,
    input logic [7:0] len, input logic [1:0] b, input int mode);
    logic bad;
    rbeat_t e;
    bad = is_bad(b, len);
    for (int i = 0; i <= len; i++) begin
      e.d  = bad ? 32'h0 : model[beat_addr(a, b, len, i)];
      e.l  = (i == len);
      e.r  = bad ? 2'b10 : 2'b00;
      e.id = id;
      rq.push_back(e);
    end
    send_ar(a, id, len, b);
    recv_r(mode);
  endtask

  initial begin
    int a0, r0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clock);
    reset_ni = 1;
    #1;
    check("en_delay", awready, 0);
    @(negedge clock);
    #1;
    check("en_awready", awready, 1);
    @(negedge clock);

    // Simultaneous AW/AR requests alternate starting with write.
    for (int r = 0; r < 2; r++) begin
      a0 = aw_cnt; r0 = ar_cnt;
      arvalid = 1; araddr = 10'(100 + r); arid = 4'd5;
      arlen = 0; arburst = 2'b01;
      awvalid = 1; awaddr = 10'(100 + r); awid = 4'd9;
      awlen = 0; awburst = 2'b01;
      #1;
      check("arb_aw_grant", awready, 1);
      check("arb_ar_hold", arready, 0);
      write_burst(10'(100 + r), 4'd9, 0, 2'b01, 1,
                  32'hC0DE0000 + r, 0, 4'hf);
      check("arb_ar_wait", ar_cnt, r0);
      read_burst(10'(100 + r), 4'd5, 0, 2'b01, 0);
      check("arb_aw_once", aw_cnt, a0 + 1);
      check("arb_ar_once", ar_cnt, r0 + 1);
    end

    write_burst(0, 4'd3, 3, 2'b01, 4, 32'h11111111, 32'h11111111, 4'hf);
    rq.push_back({32'h11111111, 1'b0, 2'b00, 4'd7});
    rq.push_back({32'h22222222, 1'b0, 2'b00, 4'd7});
    rq.push_back({32'h33333333, 1'b0, 2'b00, 4'd7});
    rq.push_back({32'h44444444, 1'b1, 2'b00, 4'd7});
    send_ar(0, 4'd7, 3, 2'b01);
    #1;
    check("r_first_latency", rvalid, 1);
    recv_r(0);

    write_burst(20, 4'd1, 0, 2'b01, 1, 32'hFFFFFFFF, 0, 4'hf);
    write_burst(20, 4'd2, 0, 2'b01, 1, 32'hA5A5A5A5, 0, 4'h5);
    check("strb_model", model[20], 32'hFFA5FFA5);
    read_burst(20, 4'd4, 0, 2'b01, 0);

    write_burst(200, 4'd6, 7, 2'b01, 8, 32'h01020304, 32'h10101010, 4'hf);
    read_burst(200, 4'd8, 7, 2'b01, 1);

    write_burst(40, 4'd2, 3, 2'b01, 2, 32'hAAAA0000, 1, 4'hf);
    write_burst(50, 4'd3, 3, 2'b01, 4, 32'h50500000, 1, 4'hf);
    write_burst(50, 4'd4, 1, 2'b01, 4, 32'hDEAD0000, 1, 4'hf);
    read_burst(50, 4'd5, 3, 2'b01, 0);

    write_burst(4, 4'd1, 3, 2'b01, 4, 32'h40400000, 1, 4'hf);
    read_burst(6, 4'd9, 3, 2'b10, 0);
    write_burst(60, 4'd1, 0, 2'b01, 1, 32'h60606060, 0, 4'hf);
    write_burst(60, 4'd2, 1, 2'b11, 2, 32'hBAD00000, 1, 4'hf);
    read_burst(60, 4'd3, 1, 2'b11, 0);
    read_burst(60, 4'd3, 0, 2'b01, 0);

    // Reset in the middle of a stalled read burst.
    send_ar(200, 4'd6, 7, 2'b01);
    #1;
    check("mid_rvalid", rvalid, 1);
    reset_ni = 0;
    #1;
    check("rst2_rvalid", rvalid, 0);
    check("rst2_rdata", rdata, 0);
    check("rst2_rid", rid, 0);
    check("rst2_arready", arready, 0);
    check("rst2_wready", wready, 0);
    @(negedge clock);
    reset_ni = 1;
    @(negedge clock);
    write_burst(300, 4'd2, 1, 2'b01, 2, 32'h30003000, 1, 4'hf);
    read_burst(300, 4'd3, 1, 2'b01, 0);
    read_burst(200, 4'd6, 1, 2'b01, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
